// File: rtl/ascon_permutation_engine_if.sv
// Handshake and state bus between the ASCON mode FSM (master) and the
// iterative permutation engine (slave). The 320-bit state is S_0..S_4 with
// S_0 in the most significant 64 bits.
interface ascon_permutation_engine_if;
  logic         start_i;
  logic [319:0] state_i;
  logic [319:0] state_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, state_i,
    input  state_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, state_i,
    output state_o, round_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_permutation_engine.sv
// Iterative ASCON permutation p^a / p^b over a 320-bit state register.
// Each RUN cycle applies constant addition (pc), the 5-bit S-box layer (ps)
// and the linear diffusion layer (pl). ROUNDS selects how many of the last
// rounds are applied: the first round index is 12 - ROUNDS.
// Optional build macro ASCON_DOUBLE_ROUND_EN chains two rounds per clock
// edge (ROUNDS must then be even); the final state is the same either way.
module ascon_permutation_engine #(
  parameter int ROUNDS = 12
) (
  input  logic clock_i,
  input  logic reset_i,
  ascon_permutation_engine_if.slave bus
);

`ifdef ASCON_DOUBLE_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic [3:0] FIRST_ROUND = 4'(12 - ROUNDS);
  localparam logic [3:0] LAST_START  = 4'(12 - STEP);
  localparam logic [3:0] STEP_INC    = 4'(STEP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (ROUNDS < 1 || ROUNDS > 12) begin : g_bad_rounds
    $error("ascon_permutation_engine: ROUNDS must be in 1..12");
  end

`ifdef ASCON_DOUBLE_ROUND_EN
  if ((ROUNDS % 2) != 0) begin : g_odd_rounds
    $error("ascon_permutation_engine: ROUNDS must be even in double-round mode");
  end
`endif

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                               input logic [3:0]   r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    c  = {4'hF - r, r};
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  logic [319:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [1:0]   fsm_q, fsm_d;
  logic [319:0] round1_state;
  logic [319:0] step_state;

  assign round1_state = ascon_round(state_q, round_q);
`ifdef ASCON_DOUBLE_ROUND_EN
  assign step_state = ascon_round(round1_state, round_q + 4'd1);
`else
  assign step_state = round1_state;
`endif

  // Round sequencing: load on start, advance one step per edge, pulse done.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fsm_d   = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          round_d = FIRST_ROUND;
          busy_d  = 1'b1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = step_state;
        round_d = round_q + STEP_INC;
        if (round_q == LAST_START) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          fsm_d  = DONE;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that also aborts a running permutation.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fsm_q   <= IDLE;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fsm_q   <= fsm_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for ascon_permutation_engine: p^12 and p^6 instances,
// start-while-busy, start-in-DONE and reset-mid-run sequences. Expected
// states come from a table-driven software model of the ASCON round.
module tb_ascon_permutation_engine;

`ifdef ASCON_DOUBLE_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int N12 = 12 / STEP;
  localparam int N6  = 6 / STEP;

  localparam logic [319:0] INIT_STATE = {64'h00001000808C0001, 64'h6CB10AD9CA912F80,
                                         64'h691AED630E81901F, 64'h0C4C36A20853217C,
                                         64'h46487B3E06D9D7A8};
  localparam logic [319:0] ALT_STATE  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                         64'h0F1E2D3C4B5A6978, 64'hA5A5A5A55A5A5A5A,
                                         64'hDEADBEEFCAFEF00D};

  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;
  logic [319:0] expP12;
  logic [319:0] expP6;
  logic [319:0] expAlt;
  int   doneSeen;

  ascon_permutation_engine_if bus12 ();
  ascon_permutation_engine_if bus6 ();

  ascon_permutation_engine #(.ROUNDS(12)) dut12 (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus12.slave)
  );

  ascon_permutation_engine #(.ROUNDS(6)) dut6 (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus6.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] rotrModel(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[(i + n) % 64];
    return y;
  endfunction

  function automatic logic [319:0] modelRound(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sub;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ RC[r];
    for (int j = 0; j < 64; j++) begin
      col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      sub = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][j] = sub[4 - i];
    end
    for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotrModel(y[i], ROT_A[i]) ^ rotrModel(y[i], ROT_B[i]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] modelPerm(input logic [319:0] s, input int first, input int count);
    logic [319:0] t;
    t = s;
    for (int r = first; r < first + count; r++) t = modelRound(t, r);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic start12, input logic start6);
    reset         = rst;
    bus12.start_i = start12;
    bus6.start_i  = start6;
    @(posedge clock);
    #1;
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    reset         = 1'b1;
    bus12.start_i = 1'b0;
    bus12.state_i = INIT_STATE;
    bus6.start_i  = 1'b0;
    bus6.state_i  = INIT_STATE;
    expP12 = modelPerm(INIT_STATE, 0, 12);
    expP6  = modelPerm(INIT_STATE, 6, 6);
    expAlt = modelPerm(ALT_STATE, 0, 12);

    // Reset held for two edges
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset state12", bus12.state_o, '0);
    checkOutput("reset round12", bus12.round_o, '0);
    checkOutput("reset busy12", bus12.busy_o, '0);
    checkOutput("reset done12", bus12.done_o, '0);
    checkOutput("reset state6", bus6.state_o, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle busy12", bus12.busy_o, '0);

    // p^12 start edge
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("p12 load state", bus12.state_o, INIT_STATE);
    checkOutput("p12 load round", bus12.round_o, 320'd0);
    checkOutput("p12 load busy", bus12.busy_o, 320'd1);
    checkOutput("p12 load done", bus12.done_o, 320'd0);

    // Rounds, with an ignored start while busy
    for (int k = 1; k <= N12; k++) begin
      bus12.state_i = (k == 4) ? ALT_STATE : INIT_STATE;
      applyStimulus(1'b0, (k == 4), 1'b0);
      checkOutput($sformatf("p12 done edge %0d", k), bus12.done_o, 320'(k == N12));
      if (k == 1) begin
        checkOutput("p12 first round state", bus12.state_o, modelPerm(INIT_STATE, 0, STEP));
        checkOutput("p12 first round index", bus12.round_o, 320'(STEP));
      end
    end
    checkOutput("p12 result", bus12.state_o, expP12);
    checkOutput("p12 final round", bus12.round_o, 320'd12);
    checkOutput("p12 final busy", bus12.busy_o, 320'd0);

    // Start during DONE must be ignored
    bus12.state_i = ALT_STATE;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("done-cycle start busy", bus12.busy_o, 320'd0);
    checkOutput("done pulse width", bus12.done_o, 320'd0);
    checkOutput("done-cycle start state", bus12.state_o, expP12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle hold state", bus12.state_o, expP12);
    checkOutput("idle hold round", bus12.round_o, 320'd12);
    checkOutput("idle hold busy", bus12.busy_o, 320'd0);

    // p^6 on the second instance
    bus6.state_i = INIT_STATE;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("p6 load round", bus6.round_o, 320'd6);
    checkOutput("p6 load state", bus6.state_o, INIT_STATE);
    for (int k = 1; k <= N6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("p6 done edge %0d", k), bus6.done_o, 320'(k == N6));
    end
    checkOutput("p6 result", bus6.state_o, expP6);
    checkOutput("p6 final round", bus6.round_o, 320'd12);

    // Reset in the middle of a p^12 run
    bus12.state_i = INIT_STATE;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort state", bus12.state_o, '0);
    checkOutput("abort round", bus12.round_o, '0);
    checkOutput("abort busy", bus12.busy_o, '0);
    checkOutput("abort done", bus12.done_o, '0);
    doneSeen = 0;
    for (int k = 1; k <= N12 + 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (bus12.done_o !== 1'b0) doneSeen++;
    end
    checkOutput("abort no done pulse", 320'(doneSeen), 320'd0);

    // Fresh run after the abort
    bus12.state_i = ALT_STATE;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rerun load state", bus12.state_o, ALT_STATE);
    for (int k = 1; k <= N12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rerun done edge %0d", k), bus12.done_o, 320'(k == N12));
    end
    checkOutput("rerun result", bus12.state_o, expAlt);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_engine.md
Name: ascon_permutation_engine

Overview:
- Iterative ASCON permutation p^a / p^b. Applies constant addition, substitution layer and linear diffusion once per round over a 320-bit type_state register (ascon_pack).
- Round count is parametrised; start/done handshake.
- Successor to the combinational addition_constante stage: adds round sequencing, a round counter, a configurable round count and an optional two-rounds-per-cycle mode.
- Sits between the ASCON mode FSM (init/absorb/finalise) and the state register datapath.

Parameters:
ROUNDS, 12, number of rounds per permutation; legal 1..12 (6, 8 and 12 in use); first round index = 12 - ROUNDS.

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  request one permutation on state_i; sampled only in IDLE
state_i  in  320 (type_state)  input state S_0..S_4, S_0 in MSBs
state_o  out 320 (type_state)  working/result state register
round_o  out 4  index of the next round to apply (0..11)
busy_o   out 1  high while rounds are running
done_o   out 1  one-cycle pulse; state_o valid result

Behaviour:
- Single clock domain; every register is updated only on the rising edge of clock_i. reset_i is synchronous and active-high.
- Reset values: state_o = 0, round_o = 0, busy_o = 0, done_o = 0; FSM = IDLE. Reset has priority over every other input, including mid-permutation: the run is aborted, no done_o pulse, state_o cleared.
- FSM states:
  - IDLE
    - start_i = 1: load state_o <= state_i, round_o <= 12-ROUNDS, busy_o <= 1, go to RUN.
    - Otherwise: hold state_o (last result stays visible).
  - RUN
    - Each edge: state_o <= pl(ps(pc(state_o, round_o))); round_o += 1.
    - When the round applied is 11: busy_o <= 0, done_o <= 1, go to DONE.
  - DONE
    - One cycle: done_o <= 0, go to IDLE.
    - start_i is ignored here; the next start is accepted from IDLE only.
- start_i while busy_o or done_o is high is ignored, with no queuing.
- Latency: the start edge is edge 0; done_o is high in the cycle after edge ROUNDS, i.e. ROUNDS cycles after the start edge. Throughput is one permutation per ROUNDS+2 cycles.
- pc: S_2[7:0] ^= c_r with c_r = {4'hF - r, 4'h0 + r}. Values are 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B. S_0, S_1, S_3, S_4 and S_2[63:8] are untouched.
- ps: ASCON 5-bit S-box from ascon_pack, applied to each of the 64 bit-columns. S_0 bit is the column MSB.
- pl: S_i ^= (S_i >>> a) ^ (S_i >>> b), with (a,b) = (19,28), (61,39), (1,6), (10,17), (7,41) for S_0..S_4.
- round_o wrap: after round 11, round_o returns to 12-ROUNDS on the next start. round_o never exceeds 11 in RUN; in DONE/IDLE it holds 12 (4'hC) until the next start.
- ROUNDS = 12 with first round 0 is the p^a init/finalise configuration; ROUNDS = 6 with first round 6 is p^b.

Optional Feature:
- Macro: ASCON_DOUBLE_ROUND_EN.
- Defined: two complete rounds are chained combinationally per RUN edge and round_o advances by 2. ROUNDS must be even, otherwise an elaboration $error. done_o is high ROUNDS/2 cycles after the start edge.
- Undefined: one round per edge, as above.
- The final state value is identical in both builds.

Test Plan:
- Reset behaviour: reset_i = 1 for 2 cycles -> state_o = 0, round_o = 0, busy_o = 0, done_o = 0.
- Full p^12 on the init state: ROUNDS = 12, start_i pulse with state_i = {00001000808C0001, 6CB10AD9CA912F80, 691AED630E81901F, 0C4C36A20853217C, 46487B3E06D9D7A8}.
  - After edge 0: state_o equals state_i and round_o = 0.
  - done_o high exactly 12 cycles after the start edge, for 1 cycle.
  - state_o equals the ascon_pack software model p12 result.
- Constant check on round 0: the model of pc alone on the vector above gives S_2 = 691AED630E8190EF. The engine's first-round result must equal ps/pl of that value; the bench compares after edge 1.
- p^6: ROUNDS = 6 -> round_o = 6 after the start edge; done_o 6 cycles later; result equals the model with rounds 6..11.
- Start while busy: a second start_i at cycle 3 with a different state_i -> ignored; result and done timing unchanged. A start at the DONE cycle is also ignored.
- Reset mid-run: reset_i at cycle 5 of p12 -> no done_o pulse; outputs return to reset values next edge; a new start then completes normally in 12 cycles.
